// File: rtl/decode_regfile_pkg.sv
// Shared constants for the decode-stage register file and its load scoreboard.
package decode_regfile_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        RDSRC_PC  = 2'd0,
        RDSRC_ALU = 2'd1,
        RDSRC_MEM = 2'd2
    } rdsrc_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Load scoreboard: one pending bit per register, set by an issuing load and
// cleared by its writeback or by a flush of that load; drives the decode stall.
module regfile_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = decode_regfile_pkg::REG_AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rd_write_w,
    input  logic [AW-1:0]   rd_w,
    input  logic [AW-1:0]   rs1_d,
    input  logic [AW-1:0]   rs2_d,
    input  logic            rs1_en_d,
    input  logic            rs2_en_d,
    input  logic            issue_d,
    input  logic            issue_load_d,
    input  logic [AW-1:0]   issue_rd_d,
    input  logic            kill_e,
    input  logic            kill_load_e,
    input  logic [AW-1:0]   kill_rd_e,
    output logic            stall_d,
    output logic [NREG-1:0] pending_o
);
    import decode_regfile_pkg::*;

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;
    logic            hz1;
    logic            hz2;
    logic            load_go;

    // A source being written back this cycle is served by the bypass, not stalled.
    always_comb begin
        hz1     = rs1_en_d && (rs1_d != REG_ZERO) && pending_q[rs1_d]
                  && !(rd_write_w && (rd_w == rs1_d));
        hz2     = rs2_en_d && (rs2_d != REG_ZERO) && pending_q[rs2_d]
                  && !(rd_write_w && (rd_w == rs2_d));
        stall_d = issue_d && (hz1 || hz2);
        load_go = issue_d && !stall_d && issue_load_d;
    end

    // Set is evaluated last so a newly issued load owns the register over any clear.
    always_comb begin
        pending_d = pending_q;
        for (int i = 1; i < NREG; i++) begin
            if (rd_write_w && (rd_w == AW'(i)))
                pending_d[i] = 1'b0;
            if (kill_e && kill_load_e && (kill_rd_e == AW'(i)))
                pending_d[i] = 1'b0;
            if (load_go && (issue_rd_d == AW'(i)))
                pending_d[i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pending_q <= '0;
        else
            pending_q <= pending_d;
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/decode_regfile.sv
// Decode-stage integer register file with writeback write-through bypass on
// both read ports, plus the load-use scoreboard.
module decode_regfile #(
    parameter int XLEN = decode_regfile_pkg::XLEN,
    parameter int NREG = 32,
    parameter int AW   = decode_regfile_pkg::REG_AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rd_write_w,
    input  logic [AW-1:0]   rd_w,
    input  logic [XLEN-1:0] rd_data_w,
    input  logic [AW-1:0]   rs1_d,
    input  logic [AW-1:0]   rs2_d,
    input  logic            rs1_en_d,
    input  logic            rs2_en_d,
    output logic [XLEN-1:0] rs1_data_d,
    output logic [XLEN-1:0] rs2_data_d,
    input  logic            issue_d,
    input  logic            issue_load_d,
    input  logic [AW-1:0]   issue_rd_d,
    input  logic            kill_e,
    input  logic            kill_load_e,
    input  logic [AW-1:0]   kill_rd_e,
    output logic            stall_d,
    output logic [NREG-1:0] pending_o
);
    import decode_regfile_pkg::*;

    logic [XLEN-1:0] regs_q [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
        end else if (rd_write_w && (rd_w != REG_ZERO)) begin
            regs_q[rd_w] <= rd_data_w;
        end
    end

    // x0 reads as zero even while a write to x0 is presented on the bypass.
    always_comb begin
        rs1_data_d = regs_q[rs1_d];
        if (rs1_d == REG_ZERO)
            rs1_data_d = '0;
        else if (rd_write_w && (rd_w == rs1_d))
            rs1_data_d = rd_data_w;

        rs2_data_d = regs_q[rs2_d];
        if (rs2_d == REG_ZERO)
            rs2_data_d = '0;
        else if (rd_write_w && (rd_w == rs2_d))
            rs2_data_d = rd_data_w;
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_write_w   (rd_write_w),
        .rd_w         (rd_w),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .rs1_en_d     (rs1_en_d),
        .rs2_en_d     (rs2_en_d),
        .issue_d      (issue_d),
        .issue_load_d (issue_load_d),
        .issue_rd_d   (issue_rd_d),
        .kill_e       (kill_e),
        .kill_load_e  (kill_load_e),
        .kill_rd_e    (kill_rd_e),
        .stall_d      (stall_d),
        .pending_o    (pending_o)
    );

endmodule

// File: tb/tb_decode_regfile.sv
// Directed and randomized checks of decode_regfile against a reference model
// of the architectural register contents and the set of in-flight load targets.
module tb_decode_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_write_w;
    logic [4:0]  rd_w;
    logic [31:0] rd_data_w;
    logic [4:0]  rs1_d;
    logic [4:0]  rs2_d;
    logic        rs1_en_d;
    logic        rs2_en_d;
    logic [31:0] rs1_data_d;
    logic [31:0] rs2_data_d;
    logic        issue_d;
    logic        issue_load_d;
    logic [4:0]  issue_rd_d;
    logic        kill_e;
    logic        kill_load_e;
    logic [4:0]  kill_rd_e;
    logic        stall_d;
    logic [31:0] pending_o;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] regs_m [32];
    logic [31:0] pend_m;

    decode_regfile dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_write_w   (rd_write_w),
        .rd_w         (rd_w),
        .rd_data_w    (rd_data_w),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .rs1_en_d     (rs1_en_d),
        .rs2_en_d     (rs2_en_d),
        .rs1_data_d   (rs1_data_d),
        .rs2_data_d   (rs2_data_d),
        .issue_d      (issue_d),
        .issue_load_d (issue_load_d),
        .issue_rd_d   (issue_rd_d),
        .kill_e       (kill_e),
        .kill_load_e  (kill_load_e),
        .kill_rd_e    (kill_rd_e),
        .stall_d      (stall_d),
        .pending_o    (pending_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) regs_m[i] = 32'h0;
        pend_m = 32'h0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (rd_write_w && rd_w == a) return rd_data_w;
        return regs_m[a];
    endfunction

    function automatic logic src_waits(input logic en, input logic [4:0] a);
        return en && (a != 5'd0) && pend_m[a] && !(rd_write_w && rd_w == a);
    endfunction

    function automatic logic model_stall();
        return issue_d && (src_waits(rs1_en_d, rs1_d) || src_waits(rs2_en_d, rs2_d));
    endfunction

    task automatic idle();
        rd_write_w = 0; rd_w = 0; rd_data_w = 0;
        rs1_d = 0; rs2_d = 0; rs1_en_d = 0; rs2_en_d = 0;
        issue_d = 0; issue_load_d = 0; issue_rd_d = 0;
        kill_e = 0; kill_load_e = 0; kill_rd_e = 0;
    endtask

    // Check all outputs against the model, then clock once and advance the model.
    task automatic step(input string tag);
        logic        st;
        logic [31:0] np;
        logic        wb;
        logic [4:0]  wa;
        logic [31:0] wd;
        #2;
        st = model_stall();
        chk({tag, ":rs1"}, rs1_data_d, model_read(rs1_d));
        chk({tag, ":rs2"}, rs2_data_d, model_read(rs2_d));
        chk({tag, ":stall"}, {31'b0, stall_d}, {31'b0, st});
        chk({tag, ":pend"}, pending_o, pend_m);
        np = pend_m;
        if (rd_write_w) np[rd_w] = 1'b0;
        if (kill_e && kill_load_e) np[kill_rd_e] = 1'b0;
        if (issue_d && !st && issue_load_d && issue_rd_d != 5'd0) np[issue_rd_d] = 1'b1;
        np[0] = 1'b0;
        wb = rd_write_w && (rd_w != 5'd0);
        wa = rd_w;
        wd = rd_data_w;
        @(posedge clk);
        pend_m = np;
        if (wb) regs_m[wa] = wd;
        #1;
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 0;
        #2;
        chk("reset_stall", {31'b0, stall_d}, 32'h0);
        chk("reset_pend", pending_o, 32'h0);
        #10;
        rst_n = 1;
        @(posedge clk);
        #1;

        rs1_d = 5; rs2_d = 0;
        #2;
        chk("rd_x5_after_reset", rs1_data_d, 32'h0);
        chk("rd_x0_after_reset", rs2_data_d, 32'h0);
        step("read_init");

        idle(); rd_write_w = 1; rd_w = 5; rd_data_w = 32'hDEADBEEF;
        step("wr_x5");
        idle(); rs1_d = 5;
        #2;
        chk("rd_x5", rs1_data_d, 32'hDEADBEEF);
        step("rd_x5_step");

        idle(); rd_write_w = 1; rd_w = 7; rd_data_w = 32'h12345678; rs1_d = 7; rs2_d = 7;
        #2;
        chk("bypass_rs1", rs1_data_d, 32'h12345678);
        chk("bypass_rs2", rs2_data_d, 32'h12345678);
        step("bypass");

        idle(); rd_write_w = 1; rd_w = 0; rd_data_w = 32'hFFFFFFFF; rs1_d = 0;
        #2;
        chk("x0_bypass", rs1_data_d, 32'h0);
        step("wr_x0");
        idle(); rs1_d = 0;
        step("rd_x0");

        idle(); issue_d = 1; issue_load_d = 1; issue_rd_d = 3;
        step("ld_x3");
        idle(); issue_d = 1; issue_rd_d = 10; rs1_d = 3; rs1_en_d = 1;
        #2;
        chk("use_x3_stall", {31'b0, stall_d}, 32'h1);
        step("use_x3_a");
        step("use_x3_b");
        rd_write_w = 1; rd_w = 3; rd_data_w = 32'hA5;
        #2;
        chk("wb_x3_nostall", {31'b0, stall_d}, 32'h0);
        chk("wb_x3_data", rs1_data_d, 32'hA5);
        step("wb_x3");
        idle();
        #2;
        chk("x3_cleared", pending_o & 32'h8, 32'h0);
        step("after_x3");

        idle(); issue_d = 1; issue_load_d = 1; issue_rd_d = 4;
        step("ld_x4");
        idle(); issue_d = 1; rs2_d = 4; rs2_en_d = 0;
        #2;
        chk("x4_unused_src", {31'b0, stall_d}, 32'h0);
        step("x4_unused");
        idle(); issue_d = 1; issue_load_d = 1; issue_rd_d = 0;
        step("ld_x0");
        idle();
        #2;
        chk("ld_x0_no_pend", pending_o, 32'h10);
        step("after_ld_x0");
        idle(); rd_write_w = 1; rd_w = 4; rd_data_w = 32'h44;
        step("wb_x4");

        idle(); issue_d = 1; issue_load_d = 1; issue_rd_d = 6;
        step("ld_x6");
        idle(); rd_write_w = 1; rd_w = 6; rd_data_w = 32'h66;
        issue_d = 1; issue_load_d = 1; issue_rd_d = 6;
        step("wb_and_ld_x6");
        idle();
        #2;
        chk("set_wins_x6", pending_o, 32'h40);
        step("after_x6");
        idle(); rd_write_w = 1; rd_w = 6; rd_data_w = 32'h67;
        step("wb_x6");

        idle(); issue_d = 1; issue_load_d = 1; issue_rd_d = 9;
        step("ld_x9");
        idle(); kill_e = 1; kill_load_e = 1; kill_rd_e = 9;
        step("kill_x9");
        idle(); issue_d = 1; rs1_d = 9; rs1_en_d = 1;
        #2;
        chk("x9_killed", pending_o & 32'h200, 32'h0);
        chk("x9_no_stall", {31'b0, stall_d}, 32'h0);
        step("use_x9");

        idle(); issue_d = 1; issue_load_d = 1; issue_rd_d = 11;
        step("ld_x11");
        idle(); issue_d = 1; rs1_d = 11; rs1_en_d = 1;
        #2;
        chk("use_x11_stall", {31'b0, stall_d}, 32'h1);
        step("use_x11");
        rst_n = 0;
        #1;
        chk("midrst_stall", {31'b0, stall_d}, 32'h0);
        chk("midrst_pend", pending_o, 32'h0);
        model_reset();
        #1;
        rst_n = 1;
        idle(); rs1_d = 5; rs2_d = 7;
        #2;
        chk("midrst_x5", rs1_data_d, 32'h0);
        step("post_rst");

        for (int n = 0; n < 600; n++) begin
            rd_write_w   = 1'($urandom_range(0, 1));
            rd_w         = 5'($urandom_range(0, 7));
            rd_data_w    = $urandom;
            rs1_d        = 5'($urandom_range(0, 7));
            rs2_d        = 5'($urandom_range(0, 7));
            rs1_en_d     = 1'($urandom_range(0, 1));
            rs2_en_d     = 1'($urandom_range(0, 1));
            issue_d      = ($urandom_range(0, 3) != 0);
            issue_load_d = 1'($urandom_range(0, 1));
            issue_rd_d   = 5'($urandom_range(0, 7));
            kill_e       = ($urandom_range(0, 7) == 0);
            kill_load_e  = 1'($urandom_range(0, 1));
            kill_rd_e    = 5'($urandom_range(0, 7));
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
